// File: rtl/ha_share_arb_pkg.sv
// ha_share_pkg: shared types and helpers for the shared half-adder arbiter.
// Holds the result record, output-state encoding and ID-width helper.
package ha_share_pkg;

    localparam int MAX_NREQ  = 16;
    localparam int MAX_WIDTH = 64;
    localparam int MAX_IDW   = 4;

    // Requester-ID width; never below 1 bit.
    function automatic int clog2_nreq(input int n);
        int r;
        r = 1;
        for (int k = 1; k < 5; k++) begin
            if ((1 << k) < n) r = k + 1;
        end
        return r;
    endfunction

    // Result record sized for the largest build; narrower builds use low bits.
    typedef struct packed {
        logic [MAX_WIDTH-1:0] sum;
        logic [MAX_WIDTH-1:0] carry;
        logic [MAX_IDW-1:0]   id;
    } res_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ost_e;

endpackage

// File: rtl/ha_share_arb_if.sv
// ha_share_arb_if: requester operand channels plus the single result channel.
// slave = arbiter side (req_ready/res_* out), master = producer/consumer side.
interface ha_share_arb_if
    import ha_share_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    localparam int IDW = clog2_nreq(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  res_valid;
    logic                  res_ready;
    logic [WIDTH-1:0]      res_sum;
    logic [WIDTH-1:0]      res_carry;
    logic [IDW-1:0]        res_id;
    logic                  busy;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_sum, res_carry, res_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_sum, res_carry, res_id, busy
    );

endinterface

// File: rtl/ha_rr_arb.sv
// ha_rr_arb: combinational round-robin grant generator (no state).
// Ports: i_req/i_ptr/i_en in; o_gnt (one-hot), o_win (index), o_any out.
module ha_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    input  logic            i_en,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_win,
    output logic            o_any
);

    always_comb begin
        int            w_idx;
        logic [IDW-1:0] w_sel;
        o_gnt = '0;
        o_win = '0;
        o_any = 1'b0;
        w_idx = 0;
        w_sel = '0;
        // Walk from farthest to nearest so the nearest hit to ptr wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= NREQ) w_idx = w_idx - NREQ;
            w_sel = IDW'(w_idx);
            if (i_req[w_sel]) begin
                o_win = w_sel;
                o_any = 1'b1;
            end
        end
        if (o_any && i_en) o_gnt[o_win] = 1'b1;
    end

endmodule

// File: rtl/ha_share_arb.sv
// ha_share_arb: round-robin share of one vector half-adder, 1-deep result reg.
// Ports: clk, rst (sync, high), bus (slave modport); grant_cnt with HA_SHARE_ARB_PERF_EN.
module ha_share_arb
    import ha_share_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    ha_share_arb_if.slave      bus
`ifdef HA_SHARE_ARB_PERF_EN
    ,
    output logic [NREQ*16-1:0] grant_cnt
`endif
);

    localparam int IDW = clog2_nreq(NREQ);

    ost_e             r_state;
    ost_e             w_state_nxt;
    logic [IDW-1:0]   r_ptr;
    res_t             r_res;
    logic             w_can_accept;
    logic             w_en;
    logic             w_any;
    logic             w_accept;
    logic [NREQ-1:0]  w_gnt;
    logic [IDW-1:0]   w_win;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;

    // A held result frees its slot in the same cycle it is consumed.
    assign w_can_accept = (r_state == ST_EMPTY) || bus.res_ready;
    assign w_en         = w_can_accept && !rst;
    assign w_accept     = w_any && w_en;

    ha_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .i_req (bus.req_valid),
        .i_ptr (r_ptr),
        .i_en  (w_en),
        .o_gnt (w_gnt),
        .o_win (w_win),
        .o_any (w_any)
    );

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == IDW'(i)) begin
                w_a = bus.req_a[i*WIDTH +: WIDTH];
                w_b = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
            ST_FULL: begin
                if (w_accept)           w_state_nxt = ST_FULL;
                else if (bus.res_ready) w_state_nxt = ST_EMPTY;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_ptr   <= '0;
            r_res   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_res.sum   <= MAX_WIDTH'(w_a ^ w_b);
                r_res.carry <= MAX_WIDTH'(w_a & w_b);
                r_res.id    <= MAX_IDW'(w_win);
                r_ptr       <= (int'(w_win) == NREQ - 1) ? '0
                                                         : w_win + IDW'(1);
            end
        end
    end

    assign bus.req_ready = w_gnt;
    assign bus.res_valid = (r_state == ST_FULL);
    assign bus.res_sum   = r_res.sum[WIDTH-1:0];
    assign bus.res_carry = r_res.carry[WIDTH-1:0];
    assign bus.res_id    = r_res.id[IDW-1:0];
    assign bus.busy      = !rst && ((r_state == ST_FULL) || (|bus.req_valid));

`ifdef HA_SHARE_ARB_PERF_EN
    logic [15:0] r_cnt [NREQ];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (rst) begin
                r_cnt[i] <= '0;
            end else if (w_accept && (int'(w_win) == i)
                         && (r_cnt[i] != 16'hFFFF)) begin
                r_cnt[i] <= r_cnt[i] + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_cnt
        assign grant_cnt[g*16 +: 16] = r_cnt[g];
    end
`endif

endmodule

// File: tb/tb_ha_share_arb.sv
// tb_ha_share_arb: directed + random stimulus against a spec-level model.
// Drives inputs on negedge, samples 1ns later; checks via immediate asserts.
module tb_ha_share_arb;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ha_share_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

`ifdef HA_SHARE_ARB_PERF_EN
    logic [NREQ*16-1:0] grant_cnt;
`endif

    ha_share_arb #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef HA_SHARE_ARB_PERF_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit         m_full = 1'b0;
    int         m_ptr  = 0;
    int         m_id   = 0;
    logic [7:0] m_sum  = '0;
    logic [7:0] m_carry = '0;
    logic [7:0] op_a [NREQ];
    logic [7:0] op_b [NREQ];
    bit         pend [NREQ];

    // Values seen on the DUT during the last cycle
    logic [NREQ-1:0]    obs_ready;
    logic               obs_valid;
    logic               obs_busy;
    logic [7:0]         obs_sum;
    logic [7:0]         obs_carry;
    logic [IDW-1:0]     obs_id;
    logic [NREQ*16-1:0] obs_cnt;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit r, input logic [NREQ-1:0] v,
                       input bit rr, input bit rnd);
        int              win;
        bit              can;
        bit              acc;
        logic [NREQ-1:0] er;
        @(negedge clk);
        if (rnd) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i]) begin
                    op_a[i] = 8'($urandom);
                    op_b[i] = 8'($urandom);
                end
            end
        end
        rst           = r;
        bus.req_valid = v;
        bus.res_ready = rr;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*WIDTH +: WIDTH] = op_a[i];
            bus.req_b[i*WIDTH +: WIDTH] = op_b[i];
        end
        can = !m_full || rr;
        win = -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (win < 0 && v[idx]) win = idx;
        end
        acc = !r && can && (win >= 0);
        er  = '0;
        if (acc) er[win] = 1'b1;
        #1;
        obs_ready = bus.req_ready;
        obs_valid = bus.res_valid;
        obs_busy  = bus.busy;
        obs_sum   = bus.res_sum;
        obs_carry = bus.res_carry;
        obs_id    = bus.res_id;
`ifdef HA_SHARE_ARB_PERF_EN
        obs_cnt   = grant_cnt;
`else
        obs_cnt   = '0;
`endif
        chk("req_ready", obs_ready, er);
        chk("busy", obs_busy, !r && (m_full || (|v)));
        chk("res_valid", obs_valid, m_full);
        if (m_full) begin
            chk("res_sum", obs_sum, m_sum);
            chk("res_carry", obs_carry, m_carry);
            chk("res_id", obs_id, m_id);
        end
        @(posedge clk);
        for (int i = 0; i < NREQ; i++)
            pend[i] = !r && v[i] && !(acc && win == i);
        if (r) begin
            m_full = 1'b0;
            m_ptr  = 0;
        end else if (acc) begin
            m_full  = 1'b1;
            m_sum   = op_a[win] ^ op_b[win];
            m_carry = op_a[win] & op_b[win];
            m_id    = win;
            m_ptr   = (win + 1) % NREQ;
        end else if (rr) begin
            m_full = 1'b0;
        end
    endtask

    initial begin
        logic [NREQ-1:0] e_gnt;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = 8'($urandom);
            op_b[i] = 8'($urandom);
            pend[i] = 1'b0;
        end
        bus.req_valid = '0;
        bus.res_ready = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);

        // Reset with every requester asking
        cyc(1'b1, 4'b1111, 1'b0, 1'b1);
        chk("rst_ready", obs_ready, 4'b0000);
        chk("rst_valid", obs_valid, 1'b0);
        chk("rst_busy", obs_busy, 1'b0);
        chk("rst_sum", obs_sum, 8'h00);
        chk("rst_carry", obs_carry, 8'h00);
        chk("rst_id", obs_id, 2'd0);
        cyc(1'b1, 4'b1111, 1'b1, 1'b1);
        cyc(1'b0, 4'b1111, 1'b1, 1'b1);
        chk("first_gnt", obs_ready, 4'b0001);
        cyc(1'b0, 4'b0000, 1'b1, 1'b1);
        chk("first_valid", obs_valid, 1'b1);
        chk("first_id", obs_id, 2'd0);
        cyc(1'b0, 4'b0000, 1'b1, 1'b1);

        // Datapath
        op_a[2] = 8'hA5;
        op_b[2] = 8'h3C;
        cyc(1'b0, 4'b0100, 1'b1, 1'b0);
        chk("dp_gnt", obs_ready, 4'b0100);
        cyc(1'b0, 4'b0000, 1'b1, 1'b1);
        chk("dp_valid", obs_valid, 1'b1);
        chk("dp_sum", obs_sum, 8'h99);
        chk("dp_carry", obs_carry, 8'h24);
        chk("dp_id", obs_id, 2'd2);

        // Fairness with wrap
        cyc(1'b1, 4'b0000, 1'b1, 1'b1);
        for (int k = 0; k < 7; k++) begin
            cyc(1'b0, 4'b1111, 1'b1, 1'b1);
            if (k > 0) begin
                chk("rr_valid", obs_valid, 1'b1);
                chk("rr_id", obs_id, 64'((k - 1) % NREQ));
            end
        end

        // Backpressure then back-to-back
        cyc(1'b1, 4'b0000, 1'b1, 1'b1);
        cyc(1'b0, 4'b0010, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 4'b1000, 1'b0, 1'b1);
            chk("bp_ready", obs_ready, 4'b0000);
            chk("bp_valid", obs_valid, 1'b1);
            chk("bp_id", obs_id, 2'd1);
        end
        cyc(1'b0, 4'b1000, 1'b1, 1'b1);
        chk("b2b_gnt", obs_ready, 4'b1000);
        chk("b2b_id", obs_id, 2'd1);
        cyc(1'b0, 4'b0000, 1'b1, 1'b1);
        chk("b2b_valid", obs_valid, 1'b1);
        chk("b2b_next_id", obs_id, 2'd3);

        // Sparse requesters starting from ptr=2
        cyc(1'b1, 4'b0000, 1'b1, 1'b1);
        cyc(1'b0, 4'b0010, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            e_gnt = (k % 2 == 0) ? 4'b1000 : 4'b0010;
            cyc(1'b0, 4'b1010, 1'b1, 1'b1);
            chk("sp_gnt", obs_ready, e_gnt);
        end

        // Random traffic
        repeat (400) begin
            cyc(($urandom_range(0, 39) == 0), NREQ'($urandom),
                ($urandom_range(0, 3) != 0), 1'b1);
        end

`ifdef HA_SHARE_ARB_PERF_EN
        cyc(1'b1, 4'b0000, 1'b1, 1'b1);
        repeat (5) cyc(1'b0, 4'b0001, 1'b1, 1'b1);
        repeat (2) cyc(1'b0, 4'b1000, 1'b1, 1'b1);
        cyc(1'b0, 4'b0000, 1'b1, 1'b1);
        chk("perf_c0", obs_cnt[15:0], 16'd5);
        chk("perf_c1", obs_cnt[31:16], 16'd0);
        chk("perf_c3", obs_cnt[63:48], 16'd2);
        cyc(1'b1, 4'b0000, 1'b1, 1'b1);
        cyc(1'b1, 4'b0000, 1'b1, 1'b1);
        chk("perf_clr", obs_cnt, 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ha_share_arb.md
Name: ha_share_arb

Overview:
- Shares one vector half-adder datapath among NREQ requesters.
- Each requester presents an operand pair (a, b) with a valid/ready handshake.
- A round-robin arbiter grants at most one requester per cycle. The granted pair is added bitwise (sum = a^b, carry = a&b).
- The result is registered with the requester ID and returned on a single valid/ready result channel.
- Sits between the operand producers and the half-adder datapath; it is the sole sequencer of that datapath.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 8, operand width in bits.
- IDW, $clog2(NREQ), requester-ID width. Derived; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_a  in  NREQ*WIDTH  operand a. Requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand b, same packing as req_a.
- req_ready  out  NREQ  per-requester accept. One-hot or zero.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_sum  out  WIDTH  a^b of the accepted pair.
- res_carry  out  WIDTH  a&b of the accepted pair.
- res_id  out  IDW  index of the requester that produced the result.
- busy  out  1  high when res_valid=1 or any req_valid=1.

Behaviour:
- Reset: all of the following are 0 on the first clk edge with rst=1 and stay 0 while rst=1: res_valid, res_sum, res_carry, res_id, req_ready, rr pointer ptr.
- Reset mid-operation: a pending result is discarded and no handshake completes in that cycle. busy=0 while rst=1, regardless of req_valid.
- Output state machine (2 states):
  - EMPTY (res_valid=0) -> FULL on accept.
  - FULL -> EMPTY when res_ready=1 and there is no new accept.
  - FULL -> FULL when res_ready=1 with a same-cycle accept (back-to-back), or when res_ready=0 (hold).
- can_accept = (state==EMPTY) or res_ready. This is combinational from res_ready.
- Arbitration (combinational):
  - Scan requesters starting at index ptr, increasing modulo NREQ.
  - The first i with req_valid[i]=1 is the winner.
  - req_ready[winner] = can_accept. All other req_ready bits are 0.
- Accept: req_valid[i] & req_ready[i]. On the accepting edge, the result registers load the sum, carry and id, and res_valid=1.
- Latency: exactly 1 cycle from the accept edge to valid result. Throughput is 1 result per cycle when res_ready is held at 1.
- Pointer: after an accept from i, ptr <= (i+1) mod NREQ. Without an accept, ptr is unchanged.
  - Wrap-around: a grant to i=NREQ-1 sets ptr=0.
- Stall: while FULL and res_ready=0, res_sum, res_carry and res_id hold stable and all req_ready bits are 0.
- Requesters must hold req_a/req_b stable while req_valid=1 and not accepted. A requester may drop valid without penalty.
- No valid requester: no accept, ptr is held, and the state follows res_ready.

Optional Feature:
- Macro: HA_SHARE_ARB_PERF_EN.
- Defined:
  - Adds output grant_cnt, NREQ*16 bits: one 16-bit count of accepts per requester.
  - Counts saturate at 16'hFFFF.
  - Counts clear on rst.
  - Count i increments on the edge where requester i is accepted.
- Undefined: the port and the counters are absent. All other behaviour is identical.

Decomposition:
- Shared package ha_share_pkg holds:
  - localparam MAX_NREQ = 16.
  - function clog2_nreq.
  - typedef res_t, a struct of {sum, carry, id} used for the result register.
- One sub-module, ha_rr_arb: a pure round-robin grant generator.
  - Inputs: req vector, ptr, en.
  - Outputs: one-hot gnt, winner index, any.
  - The pointer register stays in the top module.

Test Plan:
- Reset: apply rst=1 with req_valid=4'b1111 -> req_ready=0, res_valid=0, busy=0. Release rst with res_ready=1 -> first grant goes to req 0, res_id=0 one cycle later.
- Datapath: req 2 presents a=8'hA5, b=8'h3C, the other requesters idle -> next cycle res_valid=1, res_sum=8'h99, res_carry=8'h24, res_id=2.
- Round-robin fairness: all four requesters valid continuously, res_ready=1 -> res_id sequence 0,1,2,3,0,1 (wrap checked), one result per cycle.
- Backpressure: hold res_ready=0 for 3 cycles while FULL with res_id=1 -> outputs stable, req_ready=0 throughout. Raise res_ready with req 3 valid -> same-cycle accept, next res_id=3, no bubble.
- Sparse requests: only req 1 and req 3 valid, ptr=2 -> grant order 3,1,3,1.
- Perf feature (HA_SHARE_ARB_PERF_EN defined): 5 accepts from req 0 and 2 from req 3 -> grant_cnt[15:0]=5, grant_cnt[63:48]=2. Assert rst -> all counts 0.
